// File: rtl/note_sequencer.sv
// Beat-driven melody sequencer: steps a small pattern RAM and drives the
// oscillator note select plus a mute gate, changing the note only while muted.
module note_sequencer #(
  parameter int TICKS_PER_BEAT = 5_000_000,
  parameter int GAP_TICKS      = 250_000,
  parameter int STEPS          = 16,
  parameter int STEP_W         = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [STEP_W-1:0] WR_ADDR,
  input  logic [4:0]        WR_DATA,
  input  logic [STEP_W-1:0] LAST_STEP,
  input  logic              LOOP,
  input  logic              START,
  input  logic              STOP,
  output logic [1:0]        NOTE_SEL,
  output logic              GATE,
  output logic              BUSY,
  output logic [STEP_W-1:0] STEP_IDX,
  output logic              DONE
);

  localparam int TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [4:0]        REST_ENTRY = 5'b1_00_00;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        note_q, note_d;
  logic              gate_q, gate_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] last_q, last_d;
  logic [2:0]        beats_q, beats_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [4:0]        ram_q [STEPS];
  logic [4:0]        ram_d [STEPS];
  logic [4:0]        entry;
  logic              step_end;

  // A write lands at the next edge, so a LOAD in the same cycle sees the old entry.
  assign entry = ram_q[step_q];

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    state_d  = state_q;
    note_d   = note_q;
    gate_d   = gate_q;
    done_d   = 1'b0;
    step_d   = step_q;
    last_d   = last_q;
    beats_d  = beats_q;
    tick_d   = tick_q;
    gap_d    = gap_q;
    step_end = 1'b0;
    ram_d    = ram_q;

    if (WR_EN && (32'(WR_ADDR) < 32'(STEPS))) ram_d[WR_ADDR] = WR_DATA;

    case (state_q)
      IDLE: begin
        gate_d = 1'b0;
        if (START && !STOP) begin
          last_d  = (32'(LAST_STEP) >= 32'(STEPS)) ? STEP_W'(STEPS - 1) : LAST_STEP;
          step_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        note_d  = entry[1:0];
        beats_d = {1'b0, entry[3:2]} + 3'd1;
        tick_d  = '0;
        gate_d  = !entry[4];
        state_d = PLAY;
      end
      PLAY: begin
        if (tick_q == TICK_MAX) begin
          tick_d  = '0;
          beats_d = beats_q - 3'd1;
          if (beats_q == 3'd1) begin
            gate_d = 1'b0;
            if (GAP_TICKS == 0) begin
              step_end = 1'b1;
            end else begin
              gap_d   = '0;
              state_d = GAP;
            end
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_MAX) step_end = 1'b1;
        else                  gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (step_end) begin
      if (step_q != last_q) begin
        step_d  = step_q + STEP_W'(1);
        state_d = LOAD;
      end else if (LOOP) begin
        step_d  = '0;
        state_d = LOAD;
      end else begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    // Abort wins over everything, including a pass that completes this cycle.
    if (STOP && (state_q != IDLE)) begin
      state_d = IDLE;
      gate_d  = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      note_q  <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= '0;
      last_q  <= '0;
      beats_q <= '0;
      tick_q  <= '0;
      gap_q   <= '0;
      // NOTE: the pattern RAM is small flop storage, so reset restores every entry to a rest.
      for (int i = 0; i < STEPS; i++) ram_q[i] <= REST_ENTRY;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      step_q  <= step_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      tick_q  <= tick_d;
      gap_q   <= gap_d;
      ram_q   <= ram_d;
    end
  end

  assign NOTE_SEL = note_q;
  assign GATE     = gate_q;
  assign BUSY     = busy_q;
  assign STEP_IDX = step_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with short beats (4 ticks, 2-tick gap, 4 steps).
module tb_note_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR_EN = 1'b0;
  logic [1:0] WR_ADDR = '0;
  logic [4:0] WR_DATA = '0;
  logic [1:0] LAST_STEP = '0;
  logic       LOOP = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic [1:0] NOTE_SEL;
  logic       GATE;
  logic       BUSY;
  logic [1:0] STEP_IDX;
  logic       DONE;

  int checks = 0;
  int errors = 0;

  note_sequencer #(
    .TICKS_PER_BEAT(4),
    .GAP_TICKS     (2),
    .STEPS         (4),
    .STEP_W        (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_EN    (WR_EN),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .LAST_STEP(LAST_STEP),
    .LOOP     (LOOP),
    .START    (START),
    .STOP     (STOP),
    .NOTE_SEL (NOTE_SEL),
    .GATE     (GATE),
    .BUSY     (BUSY),
    .STEP_IDX (STEP_IDX),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [4:0] data);
    WR_ADDR = addr;
    WR_DATA = data;
    WR_EN   = 1'b1;
    step(1);
    WR_EN   = 1'b0;
  endtask

  // Pattern of test 2 (notes 1 for 2 beats, rest, note 3) seen k edges after START acceptance.
  function automatic logic exp_gate(input int k);
    return ((k >= 1) && (k <= 8)) || ((k >= 19) && (k <= 22));
  endfunction

  // All-rest RAM, four steps of 7 cycles: DONE at edge 28, GATE never rises.
  task automatic play_rests(input string tag);
    logic gate_seen;
    logic done_seen;
    gate_seen = 1'b0;
    done_seen = 1'b0;
    LAST_STEP = 2'd3;
    LOOP      = 1'b0;
    START     = 1'b1;
    step(1);
    START = 1'b0;
    check({tag, "_busy"}, BUSY, 1);
    for (int k = 1; k <= 27; k++) begin
      step(1);
      gate_seen |= GATE;
      done_seen |= DONE;
    end
    check({tag, "_gate_silent"}, gate_seen, 0);
    check({tag, "_no_early_done"}, done_seen, 0);
    step(1);
    check({tag, "_done"}, DONE, 1);
    check({tag, "_idle"}, BUSY, 0);
    step(1);
    check({tag, "_done_pulse"}, DONE, 0);
  endtask

  initial begin
    // 1: reset state, then rests only
    step(2);
    RST = 1'b0;
    check("rst_note", NOTE_SEL, 0);
    check("rst_gate", GATE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_step", STEP_IDX, 0);
    play_rests("t1");
    check("t1_note", NOTE_SEL, 0);

    // 2: three-step pattern, single pass
    wr(2'd0, 5'b0_01_01);
    wr(2'd1, 5'b1_00_00);
    wr(2'd2, 5'b0_00_11);
    LAST_STEP = 2'd2;
    LOOP      = 1'b0;
    START     = 1'b1;
    step(1);
    START = 1'b0;
    check("t2_load_gate", GATE, 0);
    for (int k = 1; k <= 25; k++) begin
      step(1);
      check("t2_gate", GATE, exp_gate(k));
      check("t2_done", DONE, k == 25);
      if (k == 1)  check("t2_note0", NOTE_SEL, 1);
      if (k == 11) check("t2_step1", STEP_IDX, 1);
      if (k == 12) check("t2_note_rest", NOTE_SEL, 0);
      if (k == 18) check("t2_step2", STEP_IDX, 2);
      if (k == 19) check("t2_note2", NOTE_SEL, 3);
    end
    check("t2_busy_end", BUSY, 0);
    step(1);
    check("t2_note_hold", NOTE_SEL, 3);

    // 3: looping, then drop LOOP in the second pass
    LOOP  = 1'b1;
    START = 1'b1;
    step(1);
    START = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step(1);
      check("t3_gate", GATE, exp_gate(k % 25));
      check("t3_done", DONE, k == 50);
      if (k == 25) begin
        check("t3_wrap_step", STEP_IDX, 0);
        check("t3_wrap_busy", BUSY, 1);
      end
      if (k == 30) LOOP = 1'b0;
    end
    check("t3_busy_end", BUSY, 0);

    // 4: STOP in PLAY, then START+STOP together in IDLE
    START = 1'b1;
    step(1);
    START = 1'b0;
    step(3);
    check("t4_playing", GATE, 1);
    STOP = 1'b1;
    step(1);
    STOP = 1'b0;
    check("t4_stop_gate", GATE, 0);
    check("t4_stop_busy", BUSY, 0);
    check("t4_stop_note", NOTE_SEL, 1);
    check("t4_stop_done", DONE, 0);
    START = 1'b1;
    STOP  = 1'b1;
    step(2);
    check("t4_both_busy", BUSY, 0);
    START = 1'b0;
    STOP  = 1'b0;
    step(2);
    check("t4_still_idle", BUSY, 0);

    // 5: rewrite the step being played, then reset mid-PLAY
    LOOP  = 1'b1;
    START = 1'b1;
    step(1);
    START = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      step(1);
      if (k >= 4 && k <= 8) begin
        check("t5_cur_gate", GATE, 1);
        check("t5_cur_note", NOTE_SEL, 1);
      end
      if (k == 9)  check("t5_cur_len", GATE, 0);
      if (k == 26) begin
        check("t5_new_note", NOTE_SEL, 2);
        check("t5_new_gate", GATE, 1);
      end
      if (k == 3) begin
        WR_ADDR = 2'd0;
        WR_DATA = 5'b0_00_10;
        WR_EN   = 1'b1;
      end
      if (k == 4) WR_EN = 1'b0;
    end
    RST  = 1'b1;
    LOOP = 1'b0;
    step(1);
    RST = 1'b0;
    check("t5_rst_note", NOTE_SEL, 0);
    check("t5_rst_gate", GATE, 0);
    check("t5_rst_busy", BUSY, 0);
    check("t5_rst_step", STEP_IDX, 0);
    check("t5_rst_done", DONE, 0);
    play_rests("t5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
